// File: rtl/bcd_sseg_scan3_pkg.sv
// Shared constants for the 3-digit seven-segment scanner.
// Segment patterns are active low, ordered g,f,e,d,c,b,a.
package bcd_sseg_scan3_pkg;

    localparam int NUM_DIGITS = 3;

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2
    } digit_e;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_sseg_scan3_bcd_to_sseg.sv
// Combinational BCD to 7-segment decoder, active-low segments.
// Ports: bcd_i (4-bit code), seg_o (g..a); codes 10..15 give a dash.
module bcd_to_sseg
    import bcd_sseg_scan3_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        unique case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_sseg_scan3.sv
// Time-multiplexed 3-digit common-anode display driver with frame snapshot.
// Ports: clk, reset, bcd2/1/0, dp_in, blank_lz -> an, sseg, frame_tick.
module bcd_sseg_scan3
    import bcd_sseg_scan3_pkg::*;
#(
    parameter int PRESCALE_W = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    input  logic [2:0] dp_in,
    input  logic       blank_lz,
    output logic [2:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic                  tick;
    digit_e                idx_q, idx_d;
    logic [3:0]            s2_q, s1_q, s0_q;
    logic [2:0]            sdp_q;
    logic                  snap;
    logic                  ft_q;
    logic [2:0]            an_q, an_d;
    logic [7:0]            sseg_q, sseg_d;
    logic [3:0]            dig;
    logic                  blank;
    logic                  dp;
    logic [6:0]            seg;

    assign tick = &cnt_q;
    // Shadows reload only at the end of the last digit of a frame.
    assign snap = tick && (idx_q == D2);

    // State register
    always_ff @(posedge clk) begin
        if (reset) idx_q <= D0;
        else       idx_q <= idx_d;
    end

    // Next-state logic
    always_comb begin
        idx_d = idx_q;
        unique case (idx_q)
            D0:      if (tick) idx_d = D1;
            D1:      if (tick) idx_d = D2;
            D2:      if (tick) idx_d = D0;
            default: idx_d = D0;
        endcase
    end

    // Output logic: pick digit, blanking and dp for the current index
    always_comb begin
        an_d  = 3'b110;
        dig   = s0_q;
        dp    = sdp_q[0];
        blank = 1'b0;
        unique case (idx_q)
            D1: begin
                an_d  = 3'b101;
                dig   = s1_q;
                dp    = sdp_q[1];
                blank = blank_lz && (s2_q == 4'd0) && (s1_q == 4'd0);
            end
            D2: begin
                an_d  = 3'b011;
                dig   = s2_q;
                dp    = sdp_q[2];
                blank = blank_lz && (s2_q == 4'd0);
            end
            default: begin
                an_d  = 3'b110;
                dig   = s0_q;
                dp    = sdp_q[0];
                blank = 1'b0;
            end
        endcase
        // A blanked digit is always a zero, so a dash is never blanked.
        sseg_d = {~dp, blank ? SEG_OFF : seg};
    end

    bcd_to_sseg u_dec (
        .bcd_i (dig),
        .seg_o (seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            s2_q   <= 4'd0;
            s1_q   <= 4'd0;
            s0_q   <= 4'd0;
            sdp_q  <= 3'b000;
            ft_q   <= 1'b0;
            an_q   <= 3'b111;
            sseg_q <= 8'hFF;
        end else begin
            cnt_q  <= cnt_q + PRESCALE_W'(1);
            ft_q   <= snap;
            an_q   <= an_d;
            sseg_q <= sseg_d;
            if (snap) begin
                s2_q  <= bcd2;
                s1_q  <= bcd1;
                s0_q  <= bcd0;
                sdp_q <= dp_in;
            end
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_bcd_sseg_scan3.sv
// Directed bench for bcd_sseg_scan3 with PRESCALE_W = 2.
// Tick every 4 clocks, one display frame every 12 clocks.
module tb_bcd_sseg_scan3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] bcd2, bcd1, bcd0;
    logic [2:0] dp_in;
    logic       blank_lz;
    logic [2:0] an;
    logic [7:0] sseg;
    logic       frame_tick;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_sseg_scan3 #(.PRESCALE_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .bcd2       (bcd2),
        .bcd1       (bcd1),
        .bcd0       (bcd0),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    task automatic wait_ft();
        bit seen;
        int i;
        seen = 0;
        i = 0;
        while (!seen && i < 40) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1;
            i++;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL ft_timeout: no frame_tick in 40 cycles");
        end
    endtask

    // Sample each digit once, starting right after a snapshot.
    task automatic capture(output logic [7:0] s0, output logic [7:0] s1,
                           output logic [7:0] s2, output logic [2:0] a0,
                           output logic [2:0] a1, output logic [2:0] a2);
        wait_ft();
        @(negedge clk);
        a0 = an; s0 = sseg;
        repeat (4) @(negedge clk);
        a1 = an; s1 = sseg;
        repeat (4) @(negedge clk);
        a2 = an; s2 = sseg;
    endtask

    task automatic test_reset();
        logic [2:0] ea;
        reset = 1'b1;
        bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0;
        dp_in = 3'b000; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (an !== 3'b111 || sseg !== 8'hFF || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold: got an=%b sseg=%h ft=%b want 111 ff 0",
                     an, sseg, frame_tick);
        end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ea = (k <= 4) ? 3'b110 : (k <= 8) ? 3'b101 : 3'b011;
            n_chk++;
            if (an !== ea || sseg !== 8'hC0) begin
                n_fail++;
                $display("FAIL rst_scan%0d: got an=%b sseg=%h want %b c0",
                         k, an, sseg, ea);
            end
        end
        n_chk++;
        if (frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ft12: got %b want 1", frame_tick);
        end
    endtask

    task automatic test_digits();
        logic [7:0] s0, s1, s2;
        logic [2:0] a0, a1, a2;
        int hits;
        logic at12;
        bcd2 = 4'd1; bcd1 = 4'd2; bcd0 = 4'd3; blank_lz = 1'b0;
        capture(s0, s1, s2, a0, a1, a2);
        n_chk++;
        if ({a0, a1, a2} !== 9'b110_101_011) begin
            n_fail++;
            $display("FAIL dig_an: got %b %b %b want 110 101 011", a0, a1, a2);
        end
        n_chk++;
        if (s0 !== 8'hB0) begin
            n_fail++; $display("FAIL dig_d0: got %h want b0", s0);
        end
        n_chk++;
        if (s1 !== 8'hA4) begin
            n_fail++; $display("FAIL dig_d1: got %h want a4", s1);
        end
        n_chk++;
        if (s2 !== 8'hF9) begin
            n_fail++; $display("FAIL dig_d2: got %h want f9", s2);
        end
        wait_ft();
        hits = 0;
        at12 = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) hits++;
            if (i == 11) at12 = frame_tick;
        end
        n_chk++;
        if (hits != 2 || at12 !== 1'b1) begin
            n_fail++;
            $display("FAIL ft_period: got %0d pulses at12=%b want 2 1",
                     hits, at12);
        end
    endtask

    task automatic test_blank_lz();
        logic [7:0] s0, s1, s2;
        logic [2:0] a0, a1, a2;
        bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd7; blank_lz = 1'b1;
        capture(s0, s1, s2, a0, a1, a2);
        n_chk++;
        if (s0 !== 8'hF8 || s1 !== 8'hFF || s2 !== 8'hFF) begin
            n_fail++;
            $display("FAIL lz_007: got %h %h %h want f8 ff ff", s0, s1, s2);
        end
        n_chk++;
        if (a1 !== 3'b101 || a2 !== 3'b011) begin
            n_fail++;
            $display("FAIL lz_an: got %b %b want 101 011", a1, a2);
        end
        blank_lz = 1'b0;
        capture(s0, s1, s2, a0, a1, a2);
        n_chk++;
        if (s0 !== 8'hF8 || s1 !== 8'hC0 || s2 !== 8'hC0) begin
            n_fail++;
            $display("FAIL nolz_007: got %h %h %h want f8 c0 c0", s0, s1, s2);
        end
        bcd2 = 4'd0; bcd1 = 4'd5; bcd0 = 4'd0; blank_lz = 1'b1;
        capture(s0, s1, s2, a0, a1, a2);
        n_chk++;
        if (s0 !== 8'hC0 || s1 !== 8'h92 || s2 !== 8'hFF) begin
            n_fail++;
            $display("FAIL lz_050: got %h %h %h want c0 92 ff", s0, s1, s2);
        end
    endtask

    task automatic test_snapshot();
        logic [7:0] s0, s1, s2;
        logic [2:0] a0, a1, a2;
        bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd4; blank_lz = 1'b0;
        wait_ft();
        @(negedge clk);
        n_chk++;
        if (sseg !== 8'h99) begin
            n_fail++; $display("FAIL snap_d0_old: got %h want 99", sseg);
        end
        repeat (4) @(negedge clk);
        bcd0 = 4'd9; bcd2 = 4'd8;
        repeat (4) @(negedge clk);
        n_chk++;
        if (an !== 3'b011 || sseg !== 8'hC0) begin
            n_fail++;
            $display("FAIL snap_d2_old: got an=%b sseg=%h want 011 c0",
                     an, sseg);
        end
        wait_ft();
        @(negedge clk);
        n_chk++;
        if (sseg !== 8'h90) begin
            n_fail++; $display("FAIL snap_d0_new: got %h want 90", sseg);
        end
        repeat (8) @(negedge clk);
        n_chk++;
        if (sseg !== 8'h80) begin
            n_fail++; $display("FAIL snap_d2_new: got %h want 80", sseg);
        end
        bcd1 = 4'hC;
        capture(s0, s1, s2, a0, a1, a2);
        n_chk++;
        if (s1 !== 8'hBF || s0 !== 8'h90 || s2 !== 8'h80) begin
            n_fail++;
            $display("FAIL dash: got %h %h %h want 90 bf 80", s0, s1, s2);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] s0, s1, s2;
        logic [2:0] a0, a1, a2;
        bcd2 = 4'd1; bcd1 = 4'd2; bcd0 = 4'd3;
        dp_in = 3'b000; blank_lz = 1'b0;
        wait_ft();
        repeat (9) @(negedge clk);
        dp_in = 3'b010;
        reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if (an !== 3'b111 || sseg !== 8'hFF || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst: got an=%b sseg=%h ft=%b want 111 ff 0",
                     an, sseg, frame_tick);
        end
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (an !== 3'b110 || sseg !== 8'hC0) begin
            n_fail++;
            $display("FAIL post_rst: got an=%b sseg=%h want 110 c0", an, sseg);
        end
        repeat (4) @(negedge clk);
        n_chk++;
        if (an !== 3'b101 || sseg !== 8'hC0) begin
            n_fail++;
            $display("FAIL post_rst_d1: got an=%b sseg=%h want 101 c0",
                     an, sseg);
        end
        capture(s0, s1, s2, a0, a1, a2);
        n_chk++;
        if (s0 !== 8'hB0 || s1 !== 8'h24 || s2 !== 8'hF9) begin
            n_fail++;
            $display("FAIL dp_d1: got %h %h %h want b0 24 f9", s0, s1, s2);
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_blank_lz();
        test_snapshot();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
